// File: rtl/mcu_pkg.sv
// Shared definitions for the 8-bit MCU control path:
// opcodes, instruction fields, ALU op codes, flag bits, FSM states.
package mcu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_INC1 = 4'h4;
  localparam logic [3:0] OP_INC2 = 4'h5;
  localparam logic [3:0] OP_DEC1 = 4'h6;
  localparam logic [3:0] OP_DEC2 = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_BC   = 4'hA;
  localparam logic [3:0] OP_BN   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_OUT  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_INC1 = 3'b100;
  localparam logic [2:0] ALU_INC2 = 3'b101;
  localparam logic [2:0] ALU_DEC1 = 3'b110;
  localparam logic [2:0] ALU_DEC2 = 3'b111;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_C = 0;

  typedef enum logic [2:0] {
    ST_START,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  // Opcodes 0x0-0x7 go through the ALU.
  function automatic logic is_alu_op(input logic [3:0] op);
    return !op[3];
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-fetch bus: req/addr from sequencer, valid/data from memory.
// master = sequencer side, slave = instruction memory side.
interface alu_sequencer_if;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic        instr_valid;
  logic [15:0] instr_data;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_valid,
    input  instr_data
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_valid,
    output instr_data
  );
endinterface

// File: rtl/ALUmodule.sv
// Combinational 8-bit ALU returning result and {N,Z,V,C}.
// Ports: operand1/2, operationSelect -> aluResult, NZVCflags.
module ALUmodule
  import mcu_pkg::*;
(
  input  logic [7:0] operand1,
  input  logic [7:0] operand2,
  input  logic [2:0] operationSelect,
  output logic [7:0] aluResult,
  output logic [3:0] NZVCflags
);

  logic [7:0] w_x;
  logic [7:0] w_y;
  logic [7:0] w_res;
  logic [8:0] w_s9;
  logic       w_sub;
  logic       w_arith;
  logic       w_v;

  always_comb begin
    w_x     = operand1;
    w_y     = operand2;
    w_sub   = 1'b0;
    w_arith = 1'b1;
    unique case (operationSelect)
      ALU_ADD:  ;
      ALU_SUB:  w_sub = 1'b1;
      ALU_AND:  w_arith = 1'b0;
      ALU_OR:   w_arith = 1'b0;
      ALU_INC1: w_y = 8'd1;
      ALU_INC2: begin
        w_x = operand2;
        w_y = 8'd1;
      end
      ALU_DEC1: begin
        w_y   = 8'd1;
        w_sub = 1'b1;
      end
      ALU_DEC2: begin
        w_x   = operand2;
        w_y   = 8'd1;
        w_sub = 1'b1;
      end
      default: ;
    endcase

    // C is carry-out for adds and borrow for subtracts.
    w_s9 = w_sub ? ({1'b0, w_x} - {1'b0, w_y})
                 : ({1'b0, w_x} + {1'b0, w_y});

    if (w_arith)
      w_res = w_s9[7:0];
    else if (operationSelect == ALU_AND)
      w_res = operand1 & operand2;
    else
      w_res = operand1 | operand2;

    w_v = w_arith
        & (w_sub ? (w_x[7] != w_y[7]) : (w_x[7] == w_y[7]))
        & (w_res[7] != w_x[7]);

    aluResult = w_res;
    NZVCflags = {w_res[7], w_res == 8'd0, w_v, w_arith & w_s9[8]};
  end

endmodule

// File: rtl/mcu_regfile.sv
// 4x8 register file: two async read ports, one sync write port.
// Ports: clk, rst, i_we/i_waddr/i_wdata, i_raddr1/2 -> o_rdata1/2.
module mcu_regfile (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic [1:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [1:0] i_raddr1,
  input  logic [1:0] i_raddr2,
  output logic [7:0] o_rdata1,
  output logic [7:0] o_rdata2
);

  logic [7:0] r_mem [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/exec sequencer driving an external ALU.
// Ports: clk, reset, bus (fetch), ALU operands/result, flags, port, halted.
module alu_sequencer
  import mcu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_sequencer_if.master         bus,
  output logic [7:0]              operand1,
  output logic [7:0]              operand2,
  output logic [2:0]              operationSelect,
  input  logic [7:0]              aluResult,
  input  logic [3:0]              NZVCflags,
  output logic [3:0]              flags,
  output logic [7:0]              port_out,
  output logic                    port_valid,
  output logic                    halted
);

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic        r_req;
  logic [7:0]  r_op1;
  logic [7:0]  r_op2;
  logic [2:0]  r_opsel;
  logic [3:0]  r_flags;
  logic [7:0]  r_port;
  logic        r_port_vld;
  logic        r_halted;

  logic [3:0]  w_op;
  logic [1:0]  w_rd;
  logic [1:0]  w_rs;
  logic [7:0]  w_imm;
  logic [7:0]  w_rdata1;
  logic [7:0]  w_rdata2;
  logic        w_we;
  logic [7:0]  w_wdata;
  logic        w_take;
  logic [7:0]  w_pc_nxt;

  assign w_op  = r_ir[OPC_HI:OPC_LO];
  assign w_rd  = r_ir[RD_HI:RD_LO];
  assign w_rs  = r_ir[RS_HI:RS_LO];
  assign w_imm = r_ir[IMM_HI:IMM_LO];

  assign w_we = (r_state == ST_EXEC)
              && (is_alu_op(w_op) || w_op == OP_LDI);
  assign w_wdata = is_alu_op(w_op) ? aluResult : w_imm;

  mcu_regfile u_rf (
    .clk      (clk),
    .rst      (reset),
    .i_we     (w_we),
    .i_waddr  (w_rd),
    .i_wdata  (w_wdata),
    .i_raddr1 (w_rd),
    .i_raddr2 (w_rs),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // Branches look at r_flags, i.e. flags from earlier instructions.
  always_comb begin
    w_take = 1'b0;
    unique case (1'b1)
      (w_op == OP_BZ):  w_take = r_flags[FLG_Z];
      (w_op == OP_BC):  w_take = r_flags[FLG_C];
      (w_op == OP_BN):  w_take = r_flags[FLG_N];
      (w_op == OP_JMP): w_take = 1'b1;
      default:          w_take = 1'b0;
    endcase
  end

  assign w_pc_nxt = w_take ? w_imm : r_pc + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_START;
      r_pc       <= RESET_PC;
      r_ir       <= 16'h0000;
      r_req      <= 1'b0;
      r_op1      <= 8'h00;
      r_op2      <= 8'h00;
      r_opsel    <= 3'b000;
      r_flags    <= 4'h0;
      r_port     <= 8'h00;
      r_port_vld <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_port_vld <= 1'b0;
      case (r_state)
        ST_START: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
        end
        ST_FETCH: begin
          if (bus.instr_valid) begin
            r_ir    <= bus.instr_data;
            r_req   <= 1'b0;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_op1   <= w_rdata1;
          r_op2   <= w_rdata2;
          r_opsel <= w_op[2:0];
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_pc <= w_pc_nxt;
          if (is_alu_op(w_op)) r_flags <= NZVCflags;
          if (w_op == OP_OUT) begin
            r_port     <= w_rdata1;
            r_port_vld <= 1'b1;
          end
          if (w_op == OP_HALT) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_START;
      endcase
    end
  end

  assign bus.instr_req    = r_req;
  assign bus.instr_addr   = r_pc;
  assign operand1         = r_op1;
  assign operand2         = r_op2;
  assign operationSelect  = r_opsel;
  assign flags            = r_flags;
  assign port_out         = r_port;
  assign port_valid       = r_port_vld;
  assign halted           = r_halted;

endmodule
